// File: rtl/matmul_stream_host.sv
// matmul_stream_host: byte-stream front end for a 3x3 signed matrix multiplier.
// The block loads A then B row-major from a valid/ready byte stream into the
// multiplier's packed buses. It then runs the core through its Enable/done
// handshake and streams the captured C back out byte by byte. It also reports
// how many cycles the core spent in RUN.
`timescale 1ns/1ps

module matmul_stream_host #(
    parameter  int N       = 3,
    parameter  int ELEM_W  = 8,
    parameter  int TIMEOUT = 1024,
    localparam int MAT_W   = N*N*ELEM_W
) (
    input  logic              Clock,
    input  logic              reset_n,
    input  logic [ELEM_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ELEM_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              mm_reset,
    output logic              mm_enable,
    output logic [MAT_W-1:0]  mm_A,
    output logic [MAT_W-1:0]  mm_B,
    input  logic [MAT_W-1:0]  mm_C,
    input  logic              mm_done,
    output logic [15:0]       cycles,
    output logic              err
);

    localparam int NE    = N*N;
    localparam int NLOAD = 2*NE;
    localparam int CNT_W = $clog2(NLOAD);
    localparam int TO_W  = $clog2(TIMEOUT+1);
    // The run counter is wide enough for both TIMEOUT and the 16-bit report.
    localparam int RUN_W = (TO_W > 16) ? TO_W : 16;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_SEND = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;          // load element k, or output element e
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [MAT_W-1:0]   mm_a_q, mm_a_d;
    logic [MAT_W-1:0]   mm_b_q, mm_b_d;
    logic [MAT_W-1:0]   c_buf_q, c_buf_d;
    logic [15:0]        cycles_q, cycles_d;
    logic               err_q, err_d;
    logic               s_ready_q, s_ready_d;

    logic               s_xfer;
    logic               m_xfer;
    logic [CNT_W-1:0]   b_idx;

    // Handshake outputs decode straight from the state register, so they are glitch-free.
    assign m_valid   = (state_q == S_SEND);
    assign mm_enable = (state_q == S_RUN);
    assign mm_reset  = (state_q != S_RUN);
    assign s_ready   = s_ready_q;
    assign mm_A      = mm_a_q;
    assign mm_B      = mm_b_q;
    assign cycles    = cycles_q;
    assign err       = err_q;
    assign m_data    = m_valid ? c_buf_q[int'(cnt_q)*ELEM_W +: ELEM_W] : '0;

    assign s_xfer = s_valid && s_ready_q;
    assign m_xfer = m_valid && m_ready;
    assign b_idx  = cnt_q - CNT_W'(NE);

    // Next-state logic: load sequencing, run supervision and output streaming.
    always_comb begin
        // NOTE: every variable is assigned its hold value first, so a branch that skips an assignment cannot infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_cnt_d = run_cnt_q;
        mm_a_d    = mm_a_q;
        mm_b_d    = mm_b_q;
        c_buf_d   = c_buf_q;
        cycles_d  = cycles_q;
        err_d     = err_q;

        unique case (state_q)
            S_LOAD: begin
                if (s_xfer) begin
                    // A fresh operation clears a previous timeout indication.
                    if (cnt_q == '0) begin
                        err_d = 1'b0;
                    end
                    if (cnt_q < CNT_W'(NE)) begin
                        mm_a_d[int'(cnt_q)*ELEM_W +: ELEM_W] = s_data;
                    end else begin
                        mm_b_d[int'(b_idx)*ELEM_W +: ELEM_W] = s_data;
                    end
                    if (cnt_q == CNT_W'(NLOAD-1)) begin
                        cnt_d     = '0;
                        run_cnt_d = RUN_W'(1);
                        state_d   = S_RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_RUN: begin
                // Completion wins over a timeout that falls on the same edge.
                if (mm_done) begin
                    c_buf_d = mm_C;
                    if (run_cnt_q > RUN_W'(16'hFFFF)) begin
                        cycles_d = 16'hFFFF;
                    end else begin
                        cycles_d = run_cnt_q[15:0];
                    end
                    cnt_d   = '0;
                    state_d = S_SEND;
                end else if (run_cnt_q >= RUN_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                end
            end

            S_SEND: begin
                // The element index moves only on a transfer, so data holds under backpressure.
                if (m_xfer) begin
                    if (cnt_q == CNT_W'(NE-1)) begin
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = S_LOAD;
            end
        endcase

        // s_ready is registered: it is high exactly when the block sits in LOAD.
        s_ready_d = (state_d == S_LOAD);
    end

    // State register; an asynchronous reset drops any partial matrix or pending result.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_LOAD;
            cnt_q     <= '0;
            run_cnt_q <= '0;
            mm_a_q    <= '0;
            mm_b_q    <= '0;
            // NOTE: the result buffer is a flat 72-bit register rather than a RAM, so it is reset so that m_data is defined.
            c_buf_q   <= '0;
            cycles_q  <= '0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register update from the same pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_cnt_q <= run_cnt_d;
            mm_a_q    <= mm_a_d;
            mm_b_q    <= mm_b_d;
            c_buf_q   <= c_buf_d;
            cycles_q  <= cycles_d;
            err_q     <= err_d;
            s_ready_q <= s_ready_d;
        end
    end

endmodule

// File: tb/tb_matmul_stream_host.sv
// tb_matmul_stream_host: randomized scoreboard bench for matmul_stream_host.
// A behavioural 3x3 multiplier answers the Enable/done handshake after a
// chosen latency. A scoreboard queue holds the expected C bytes, and a
// negedge monitor pops and compares every output transfer.
`timescale 1ns/1ps

module tb_matmul_stream_host;

    localparam int TO = 64;

    logic        Clock = 1'b0;
    logic        reset_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        mm_reset;
    logic        mm_enable;
    logic [71:0] mm_A;
    logic [71:0] mm_B;
    logic [71:0] mm_C;
    logic        mm_done;
    logic [15:0] cycles;
    logic        err;

    int          total = 0;
    int          bad   = 0;
    int          op_xfers = 0;
    int          last_cycles = 0;
    int          mult_cnt;
    int          mult_lat = 29;
    bit          done_en  = 1'b1;
    logic [71:0] junk_q;
    logic [7:0]  exp_q[$];

    always #5 Clock = ~Clock;

    matmul_stream_host #(.N(3), .ELEM_W(8), .TIMEOUT(TO)) dut (
        .Clock     (Clock),
        .reset_n   (reset_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .mm_reset  (mm_reset),
        .mm_enable (mm_enable),
        .mm_A      (mm_A),
        .mm_B      (mm_B),
        .mm_C      (mm_C),
        .mm_done   (mm_done),
        .cycles    (cycles),
        .err       (err)
    );

    // Reference product: signed 8-bit elements, each result wrapped to 8 bits.
    function automatic logic [71:0] mat_mul(input logic [71:0] a, input logic [71:0] b);
        logic [71:0] c;
        int          acc;
        c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = 0;
                for (int k = 0; k < 3; k++) begin
                    acc += int'($signed(a[(i*3+k)*8 +: 8])) * int'($signed(b[(k*3+j)*8 +: 8]));
                end
                c[(i*3+j)*8 +: 8] = acc[7:0];
            end
        end
        return c;
    endfunction

    // Behavioural multiplier core: done is raised in Enable cycle mult_lat; C is junk otherwise.
    always @(posedge Clock or negedge reset_n) begin
        if (!reset_n)                    mult_cnt <= 0;
        else if (mm_reset || !mm_enable) mult_cnt <= 0;
        else                             mult_cnt <= mult_cnt + 1;
    end

    always @(posedge Clock) junk_q <= 72'({$urandom(), $urandom(), $urandom()});

    assign mm_done = done_en && mm_enable && !mm_reset && (mult_cnt + 1 == mult_lat);
    assign mm_C    = mm_done ? mat_mul(mm_A, mm_B) : junk_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: a transfer happens at the next posedge when valid and ready are seen here.
    always @(negedge Clock) begin
        if (reset_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(m_valid), 64'd0);
            end else begin
                check("c_elem", 64'(m_data), 64'(exp_q.pop_front()));
                op_xfers++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit bubbles);
        int guard;
        bit ok;
        if (bubbles) begin
            while ($urandom_range(1, 0) == 1) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom());
                @(posedge Clock); #1;
            end
        end
        s_data  = d;
        s_valid = 1'b1;
        guard   = 0;
        ok      = 1'b0;
        while (!ok && guard < 50) begin
            @(negedge Clock);
            ok = s_ready;
            @(posedge Clock); #1;
            guard++;
        end
        s_valid = 1'b0;
        if (!ok) check("s_handshake", 64'(ok), 64'd1);
    endtask

    task automatic load_mats(input logic [71:0] a, input logic [71:0] b, input bit bubbles);
        for (int k = 0; k < 18; k++) begin
            send_byte((k < 9) ? a[k*8 +: 8] : b[(k-9)*8 +: 8], bubbles);
            if (k == 0) check("err_clear", 64'(err), 64'd0);
        end
        check("run_s_ready", 64'(s_ready), 64'd0);
        check("run_enable",  64'(mm_enable), 64'd1);
        check("run_mm_reset", 64'(mm_reset), 64'd0);
        check("mm_A_pack", 64'(mm_A[63:0]), a[63:0]);
        check("mm_A_top",  64'(mm_A[71:64]), 64'(a[71:64]));
        check("mm_B_pack", 64'(mm_B[63:0]), b[63:0]);
        check("mm_B_top",  64'(mm_B[71:64]), 64'(b[71:64]));
    endtask

    // One operation; stall_at/abort_at select a backpressure stall or a mid-stream reset (-1 = off).
    task automatic run_op(input logic [71:0] a, input logic [71:0] b, input int lat,
                          input bit bubbles, input bit rand_rdy, input int stall_at, input int abort_at);
        logic [71:0] c;
        int          guard;
        int          stalled;
        bit          saw_send;
        bit          aborted;
        c        = mat_mul(a, b);
        mult_lat = lat;
        done_en  = 1'b1;
        op_xfers = 0;
        m_ready  = 1'b1;
        for (int e = 0; e < 9; e++) exp_q.push_back(c[e*8 +: 8]);
        load_mats(a, b, bubbles);

        guard    = 0;
        stalled  = 0;
        saw_send = 1'b0;
        aborted  = 1'b0;
        while (exp_q.size() != 0 && guard < 400) begin
            if (m_valid && !saw_send) begin
                saw_send = 1'b1;
                check("send_mm_reset", 64'(mm_reset), 64'd1);
                check("send_enable",   64'(mm_enable), 64'd0);
                check("send_cycles",   64'(cycles), 64'(lat));
            end
            if (abort_at >= 0 && op_xfers == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (stall_at >= 0 && op_xfers == stall_at && m_valid && stalled < 5) begin
                m_ready = 1'b0;
                stalled++;
                @(negedge Clock);
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_data",  64'(m_data), 64'(exp_q[0]));
                @(posedge Clock); #1;
            end else begin
                m_ready = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
                @(posedge Clock); #1;
            end
            guard++;
        end
        m_ready = 1'b1;

        if (aborted) begin
            reset_n = 1'b0;
            #1;
            check("rst_m_valid",  64'(m_valid), 64'd0);
            check("rst_m_data",   64'(m_data), 64'd0);
            check("rst_mm_reset", 64'(mm_reset), 64'd1);
            check("rst_enable",   64'(mm_enable), 64'd0);
            check("rst_s_ready",  64'(s_ready), 64'd0);
            check("rst_mm_A",     64'(mm_A[63:0]), 64'd0);
            check("rst_cycles",   64'(cycles), 64'd0);
            exp_q.delete();
            repeat (2) @(posedge Clock);
            #1;
            reset_n = 1'b1;
            check("rel_s_ready_lo", 64'(s_ready), 64'd0);
            @(posedge Clock); #1;
            check("rel_s_ready_hi", 64'(s_ready), 64'd1);
            last_cycles = 0;
        end else begin
            check("drain_done", 64'(exp_q.size()), 64'd0);
            check("xfer_count", 64'(op_xfers), 64'd9);
            check("end_m_valid", 64'(m_valid), 64'd0);
            check("end_s_ready", 64'(s_ready), 64'd1);
            check("end_err",     64'(err), 64'd0);
            check("end_cycles",  64'(cycles), 64'(lat));
            if (stall_at >= 0) check("stall_count", 64'(stalled), 64'd5);
            last_cycles = lat;
        end
    endtask

    task automatic timeout_op(input logic [71:0] a, input logic [71:0] b);
        int n;
        done_en = 1'b0;
        load_mats(a, b, 1'b0);
        n = 0;
        while (!s_ready && n < 200) begin
            if (n == TO - 1) check("err_early", 64'(err), 64'd0);
            @(posedge Clock); #1;
            n++;
        end
        check("timeout_len",    64'(n), 64'(TO));
        check("timeout_err",    64'(err), 64'd1);
        check("timeout_load",   64'(mm_reset), 64'd1);
        check("timeout_cycles", 64'(cycles), 64'(last_cycles));
        check("timeout_no_out", 64'(exp_q.size()), 64'd0);
        done_en = 1'b1;
    endtask

    function automatic logic [71:0] rand_mat();
        return 72'({$urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        logic [71:0] ident;
        logic [71:0] seq;
        logic [71:0] twos;
        logic [71:0] m3;
        ident = '0;
        for (int k = 0; k < 9; k++) begin
            seq[k*8 +: 8]  = 8'(k + 1);
            twos[k*8 +: 8] = 8'h02;
            m3[k*8 +: 8]   = 8'hFD;
        end
        ident[0*8 +: 8] = 8'd1;
        ident[4*8 +: 8] = 8'd1;
        ident[8*8 +: 8] = 8'd1;

        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_s_ready",  64'(s_ready), 64'd0);
        check("reset_m_valid",  64'(m_valid), 64'd0);
        check("reset_m_data",   64'(m_data), 64'd0);
        check("reset_enable",   64'(mm_enable), 64'd0);
        check("reset_mm_reset", 64'(mm_reset), 64'd1);
        check("reset_mm_B",     64'(mm_B[63:0]), 64'd0);
        check("reset_cycles",   64'(cycles), 64'd0);
        check("reset_err",      64'(err), 64'd0);
        reset_n = 1'b1;
        check("release_s_ready_lo", 64'(s_ready), 64'd0);
        @(posedge Clock); #1;
        check("release_s_ready_hi", 64'(s_ready), 64'd1);

        // Identity times 1..9 gives 1..9 back.
        run_op(ident, seq, 29, 1'b0, 1'b0, -1, -1);
        // All 2 times all -3 gives -18 everywhere.
        run_op(twos, m3, 17, 1'b0, 1'b0, -1, -1);
        // The same product with a five-cycle stall while element 4 is presented.
        run_op(twos, m3, 5, 1'b0, 1'b0, 4, -1);
        // Random matrices, input bubbles, random backpressure; latency boundaries 1 and TIMEOUT.
        run_op(rand_mat(), rand_mat(), 1, 1'b1, 1'b1, -1, -1);
        run_op(rand_mat(), rand_mat(), TO, 1'b1, 1'b1, -1, -1);
        for (int i = 0; i < 6; i++) begin
            run_op(rand_mat(), rand_mat(), int'($urandom_range(TO - 1, 1)), 1'b1, 1'b1, -1, -1);
        end
        // No done: the run aborts with err after TIMEOUT cycles, then a normal op recovers.
        timeout_op(rand_mat(), rand_mat());
        run_op(rand_mat(), rand_mat(), 12, 1'b1, 1'b0, -1, -1);
        // Reset after three output transfers, then a full operation.
        run_op(rand_mat(), rand_mat(), 20, 1'b0, 1'b0, -1, 3);
        run_op(rand_mat(), rand_mat(), 33, 1'b1, 1'b1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
